imem_responder: RTL

Instruction-memory responder serving the fetch stage's read requests. It accepts one word-address request at a time over a valid/ready handshake and returns the 16-bit instruction a fixed number of cycles later, tagged with its address. A flush input cancels a pending read on a taken jump/branch. A side load port writes program words into the array.

---
 rtl/imem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch read at a time and returns the
// addressed word LATENCY cycles later; a side port loads program words.
module imem_responder #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   cap_data_q, cap_data_d;
    logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
    logic                cap_err_q, cap_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                accept;
    logic                rd_in_range;
    logic                ld_in_range;
    logic [DATA_W-1:0]   rd_data;

    assign req_ready   = rst && (state_q == S_IDLE || state_q == S_RESP);
    assign accept      = req_valid && req_ready;
    assign rd_in_range = req_addr < ADDR_W'(DEPTH);
    assign ld_in_range = ld_addr < ADDR_W'(DEPTH);
    // Array read is sampled at the accept edge, so a same-edge load is not seen.
    assign rd_data     = rd_in_range ? mem[req_addr[IDX_W-1:0]] : '0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;

    // Program load port, independent of the read FSM; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem[ld_addr[IDX_W-1:0]] <= ld_data;
        end
    end

    // Next-state and response output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_data_d  = cap_data_q;
        cap_addr_d  = cap_addr_q;
        cap_err_d   = cap_err_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;

        if (accept) begin
            cap_data_d = rd_data;
            cap_addr_d = req_addr;
            cap_err_d  = ~rd_in_range;
        end

        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rd_data;
                        rsp_addr_d  = req_addr;
                        rsp_err_d   = ~rd_in_range;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cap_data_q;
                    rsp_addr_d  = cap_addr_q;
                    rsp_err_d   = cap_err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_data_q  <= '0;
            cap_addr_q  <= '0;
            cap_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_data_q  <= cap_data_d;
            cap_addr_q  <= cap_addr_d;
            cap_err_q   <= cap_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
